// File: rtl/traffic_light_ctrl_if.sv
// traffic_light_ctrl_if: signal bundle between the traffic light controller and its environment.
//   tick       : one-cycle 1 s enable strobe
//   walk_btn   : pedestrian request (level or pulse)
//   sensor     : side-street vehicle present
//   main_light : {R,Y,G} one-hot, main street
//   side_light : {R,Y,G} one-hot, side street
//   walk_lamp  : pedestrian walk lamp
//   state_o    : current state code (debug)
// master drives the inputs and observes the lights; slave is the controller.
interface traffic_light_ctrl_if;
    logic       tick;
    logic       walk_btn;
    logic       sensor;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_lamp;
    logic [2:0] state_o;
    modport master (output tick, walk_btn, sensor,
                    input  main_light, side_light, walk_lamp, state_o);
    modport slave  (input  tick, walk_btn, sensor,
                    output main_light, side_light, walk_lamp, state_o);
endinterface

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-street traffic light with pedestrian walk phase and one-shot main-green extension.
//   clock : system clock, all state changes on rising edge
//   rst   : synchronous active-high reset
//   bus   : traffic_light_ctrl_if.slave (tick, walk_btn, sensor in; lights, walk_lamp, state_o out)
module traffic_light_ctrl #(
    parameter int T_MAIN = 6,
    parameter int T_SIDE = 4,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3
) (
    input logic                 clock,
    input logic                 rst,
    traffic_light_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        WALK   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4
    } state_t;

    localparam int M1    = (T_MAIN > T_SIDE) ? T_MAIN : T_SIDE;
    localparam int M2    = (T_EXT > T_YEL) ? T_EXT : T_YEL;
    localparam int M3    = (M1 > M2) ? M1 : M2;
    localparam int T_MAX = (M3 > T_WALK) ? M3 : T_WALK;
    localparam int CW    = $clog2(T_MAX) + 1;

    state_t        state, nxt;
    logic [CW-1:0] cnt, dur;
    logic          walk_req, ext_used, expire, extend;

    always_comb begin
        dur = (state == MAIN_G) ? (ext_used ? CW'(T_EXT) : CW'(T_MAIN)) :
              (state == SIDE_G) ? CW'(T_SIDE) :
              (state == WALK)   ? CW'(T_WALK) : CW'(T_YEL);
        expire = bus.tick && (cnt == dur - CW'(1));
        // first MAIN_G expiry with no side traffic re-arms the phase instead of leaving it
        extend = expire && (state == MAIN_G) && !bus.sensor && !ext_used;
        case (state)
            MAIN_G:  nxt = (expire && !extend) ? MAIN_Y : MAIN_G;
            MAIN_Y:  nxt = expire ? (walk_req ? WALK : SIDE_G) : MAIN_Y;
            WALK:    nxt = expire ? SIDE_G : WALK;
            SIDE_G:  nxt = expire ? SIDE_Y : SIDE_G;
            SIDE_Y:  nxt = expire ? MAIN_G : SIDE_Y;
            default: nxt = MAIN_G;
        endcase
    end

    // lights are decoded from the next state so they line up with the state register
    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= MAIN_G;
            cnt            <= '0;
            walk_req       <= 1'b0;
            ext_used       <= 1'b0;
            bus.main_light <= 3'b001;
            bus.side_light <= 3'b100;
            bus.walk_lamp  <= 1'b0;
            bus.state_o    <= 3'd0;
        end else begin
            state          <= nxt;
            cnt            <= (nxt != state || extend) ? '0 : cnt + CW'(bus.tick);
            ext_used       <= extend ? 1'b1 : (nxt == MAIN_Y && state != MAIN_Y) ? 1'b0 : ext_used;
            // a press on the cycle that enters WALK is already being served
            walk_req       <= (nxt == WALK && state != WALK) ? 1'b0 :
                              (bus.walk_btn && state != WALK) ? 1'b1 : walk_req;
            bus.main_light <= (nxt == MAIN_G) ? 3'b001 : (nxt == MAIN_Y) ? 3'b010 : 3'b100;
            bus.side_light <= (nxt == SIDE_G) ? 3'b001 : (nxt == SIDE_Y) ? 3'b010 : 3'b100;
            bus.walk_lamp  <= (nxt == WALK);
            bus.state_o    <= nxt;
        end
    end
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: directed and random stimulus against a countdown phase model of the traffic light.
//   drives clock/rst and the interface master side; compares every cycle on the falling edge.
module tb_traffic_light_ctrl;
    localparam int T_MAIN = 6, T_SIDE = 4, T_EXT = 3, T_YEL = 2, T_WALK = 3;
    localparam logic [2:0] MT[5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] ST[5] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
    localparam int E33S[5] = '{0, 1, 3, 4, 0};
    localparam int E33L[5] = '{6, 2, 4, 2, 6};
    localparam int E34L[5] = '{9, 2, 4, 2, 9};
    localparam int E35S[11] = '{0, 1, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    localparam int E35L[11] = '{6, 2, 4, 2, 6, 2, 3, 4, 2, 6, 2};

    logic clock = 0;
    logic rst = 1;
    traffic_light_ctrl_if b();

    traffic_light_ctrl #(.T_MAIN(T_MAIN), .T_SIDE(T_SIDE), .T_EXT(T_EXT), .T_YEL(T_YEL), .T_WALK(T_WALK))
        dut (.clock(clock), .rst(rst), .bus(b));

    always #5 clock = ~clock;

    int checks = 0, errors = 0;
    int cur_st;
    int hist[$];
    int rs[$], rl[$];

    // model: phase code, ticks left in phase, phase length, extension taken, walk pending
    int m_ph = 0, m_left = T_MAIN, m_dur = T_MAIN;
    bit m_ext = 0, m_ped = 0;
    int prev_ph, pcnt = 0;
    bit ent, hold;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic neg();
        @(negedge clock);
        cur_st = int'(b.state_o);
        hist.push_back(cur_st);
    endtask

    task automatic drive(bit r, bit t, bit w, bit s);
        #1;
        rst = r;
        b.tick = t;
        b.walk_btn = w;
        b.sensor = s;
    endtask

    task automatic cyc(bit r, bit t, bit w, bit s);
        neg();
        drive(r, t, w, s);
    endtask

    task automatic do_reset();
        repeat (3) cyc(1, 0, 0, 1);
        hist.delete();
    endtask

    task automatic calc_runs();
        rs.delete();
        rl.delete();
        foreach (hist[i]) begin
            if (rs.size() != 0 && rs[rs.size()-1] == hist[i]) rl[rl.size()-1]++;
            else begin
                rs.push_back(hist[i]);
                rl.push_back(1);
            end
        end
    endtask

    // reference model and per-cycle compare
    initial begin
        forever begin
            @(negedge clock);
            prev_ph = m_ph;
            ent = 0;
            hold = !rst && !b.tick;
            if (rst) begin
                m_ph = 0; m_left = T_MAIN; m_dur = T_MAIN; m_ext = 0; m_ped = 0;
            end else begin
                if (b.tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        case (m_ph)
                            0: if (!b.sensor && !m_ext) begin
                                   m_ext = 1; m_dur = T_EXT;
                               end else begin
                                   m_ext = 0; m_ph = 1; m_dur = T_YEL;
                               end
                            1: if (m_ped) begin
                                   ent = 1; m_ph = 2; m_dur = T_WALK;
                               end else begin
                                   m_ph = 3; m_dur = T_SIDE;
                               end
                            2: begin m_ph = 3; m_dur = T_SIDE; end
                            3: begin m_ph = 4; m_dur = T_YEL; end
                            default: begin m_ph = 0; m_dur = T_MAIN; end
                        endcase
                        m_left = m_dur;
                    end
                end
                if (ent) m_ped = 0;
                else if (b.walk_btn && prev_ph != 2) m_ped = 1;
            end
            chk("state", int'(b.state_o), m_ph);
            chk("main_light", int'(b.main_light), int'(MT[m_ph]));
            chk("side_light", int'(b.side_light), int'(ST[m_ph]));
            chk("walk_lamp", int'(b.walk_lamp), int'(m_ph == 2));
            chk("cnt", int'(dut.cnt), m_dur - m_left);
            chk("walk_req", int'(dut.walk_req), int'(m_ped));
            chk("onehot_main", int'($onehot(b.main_light)), 1);
            chk("onehot_side", int'($onehot(b.side_light)), 1);
            chk("both_go", int'(b.main_light[1:0] != 0 && b.side_light[1:0] != 0), 0);
            if (hold) chk("cnt_hold", int'(dut.cnt), pcnt);
            pcnt = int'(dut.cnt);
        end
    end

    int sgt, mgt;
    bit rst_done, left_mg, t, r;

    initial begin
        b.tick = 0; b.walk_btn = 0; b.sensor = 1;
        // continuous tick, side traffic present: 14-cycle period, no WALK
        do_reset();
        for (int j = 0; j < 30; j++) cyc(0, 1, 0, 1);
        calc_runs();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p33_state%0d", i), rs.size() > i ? rs[i] : -1, E33S[i]);
            chk($sformatf("p33_len%0d", i), rl.size() > i ? rl[i] : -1, E33L[i]);
        end
        chk("p33_no_walk", int'(hist.sum() with (int'(item == 2))), 0);
        // no side traffic: one extension per main green
        do_reset();
        for (int j = 0; j < 36; j++) cyc(0, 1, 0, 0);
        calc_runs();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("p34_state%0d", i), rs.size() > i ? rs[i] : -1, E33S[i]);
            chk($sformatf("p34_len%0d", i), rl.size() > i ? rl[i] : -1, E34L[i]);
        end
        // press in SIDE_G is served on the next cycle; press held through WALK is dropped
        do_reset();
        for (int j = 0; j < 45; j++) cyc(0, 1, (j == 9) || (j >= 21 && j <= 24), 1);
        calc_runs();
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("p35_state%0d", i), rs.size() > i ? rs[i] : -1, E35S[i]);
            chk($sformatf("p35_len%0d", i), rl.size() > i ? rl[i] : -1, E35L[i]);
        end
        // tick every 5th cycle, reset during the second SIDE_G tick period
        do_reset();
        rst_done = 0;
        sgt = 0;
        for (int j = 0; j < 400 && !rst_done; j++) begin
            neg();
            if (cur_st == 3 && sgt == 1) begin
                drive(1, 0, 0, 1);
                rst_done = 1;
            end else begin
                t = (j % 5 == 0);
                if (cur_st == 3 && t) sgt++;
                drive(0, t, 0, 1);
            end
        end
        chk("p37_reset_reached", int'(rst_done), 1);
        neg();
        chk("p37_main", int'(b.main_light), 1);
        chk("p37_side", int'(b.side_light), 4);
        chk("p37_cnt", int'(dut.cnt), 0);
        mgt = 0;
        left_mg = 0;
        for (int j = 0; j < 200 && !left_mg; j++) begin
            if (j > 0) neg();
            if (cur_st != 0) left_mg = 1;
            else begin
                t = (j % 5 == 0);
                mgt += int'(t);
                drive(0, t, 0, 1);
            end
        end
        chk("p37_left_main", int'(left_mg), 1);
        chk("p37_main_ticks", mgt, 6);
        // random traffic
        for (int j = 0; j < 4000; j++) begin
            r = ($urandom_range(0, 299) == 0);
            t = (j >= 2000) ? 1'b1 : ($urandom_range(0, 2) == 0);
            cyc(r, t, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        neg();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter T_MAIN, default 6: main-street green duration, in ticks.
REQ-002 Parameter T_SIDE, default 4: side-street green duration, in ticks.
REQ-003 Parameter T_EXT, default 3: one-time main-green extension, in ticks.
REQ-004 Parameter T_YEL, default 2: yellow duration, in ticks, for either street.
REQ-005 Parameter T_WALK, default 3: pedestrian all-red walk phase duration, in ticks.
REQ-006 clock  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 tick  in  1  one-cycle enable strobe from the 1 s divider; each cycle with tick=1 counts as one tick.
REQ-009 walk_btn  in  1  pedestrian request, level or pulse, sampled every cycle.
REQ-010 sensor  in  1  side-street vehicle present.
REQ-011 main_light  out  3  {R,Y,G} one-hot for the main street.
REQ-012 side_light  out  3  {R,Y,G} one-hot for the side street.
REQ-013 walk_lamp  out  1  high only in the WALK state.
REQ-014 state_o  out  3  current state code, for debug.

Function
REQ-015 States and codes SHALL be MAIN_G=0, MAIN_Y=1, WALK=2, SIDE_G=3, SIDE_Y=4; codes 5-7 SHALL go to MAIN_G on the next edge.
REQ-016 Outputs SHALL be Moore and registered, decoded from the state register only.
  - MAIN_G: main=001, side=100
  - MAIN_Y: main=010, side=100
  - WALK: main=100, side=100, walk_lamp=1
  - SIDE_G: main=100, side=001
  - SIDE_Y: main=100, side=010
REQ-017 cnt (width ceil(log2(max duration))+1) SHALL increment only on tick and SHALL clear to 0 on every state change.
REQ-018 A state SHALL expire on the edge where tick=1 and cnt==dur-1; the new state is visible on the cycle after that tick cycle.
REQ-019 MAIN_G duration SHALL be T_MAIN; at expiry, if sensor=0 and ext_used=0, the controller SHALL set ext_used, clear cnt, stay in MAIN_G for T_EXT more ticks, and SHALL NOT extend again.
REQ-020 ext_used SHALL clear on entry to MAIN_Y.
REQ-021 MAIN_G expiry with sensor=1 (or with ext_used=1) SHALL go to MAIN_Y.
REQ-022 MAIN_Y SHALL last T_YEL ticks, then go to WALK if walk_req=1, else to SIDE_G.
REQ-023 WALK SHALL last T_WALK ticks, then go to SIDE_G.
REQ-024 SIDE_G SHALL last T_SIDE ticks, then go to SIDE_Y.
REQ-025 SIDE_Y SHALL last T_YEL ticks, then go to MAIN_G.
REQ-026 walk_req SHALL set on any cycle with walk_btn=1 while the state is not WALK and no WALK entry occurs that cycle.
REQ-027 walk_req SHALL clear on the edge that enters WALK; a press in that same cycle SHALL be dropped, as it is already being served.
REQ-028 walk_btn while in WALK SHALL be ignored.
REQ-029 Green and yellow SHALL never be asserted on both streets in the same cycle.
REQ-030 tick held high continuously is legal; every cycle counts as one tick.

Reset
REQ-031 rst=1 at an edge SHALL force all of the following, overriding tick and any transition in the same cycle:
  - state=MAIN_G, cnt=0, walk_req=0, ext_used=0
  - main_light=001, side_light=100, walk_lamp=0, state_o=0
REQ-032 Reset asserted mid-phase SHALL abandon the current phase with no yellow.

Verification
REQ-033 Release rst; tick=1 every cycle; sensor=1; walk_btn=0 -> MAIN_G 6 cycles, MAIN_Y 2, SIDE_G 4, SIDE_Y 2, then MAIN_G again (14-cycle period), WALK never entered.
REQ-034 sensor=0 throughout, tick every cycle -> MAIN_G lasts 9 cycles (6+3), MAIN_Y 2; exactly one extension per cycle of the sequence.
REQ-035 Pulse walk_btn for 1 cycle during SIDE_G -> that sequence skips WALK; on the next MAIN_Y expiry -> WALK for 3 ticks with main=side=100, walk_lamp=1; walk_req=0 afterwards.
REQ-036 walk_btn held high across the whole WALK phase -> walk_req=0 on WALK exit; the following sequence goes MAIN_Y -> SIDE_G with no WALK.
REQ-037 tick one cycle in 5, assert rst in the 2nd SIDE_G tick period -> next cycle main=001, side=100, cnt=0; after release, MAIN_G holds for exactly 6 ticks.
REQ-038 All runs: assert that the light outputs are one-hot, that REQ-029 holds, and that cnt does not advance on non-tick cycles.
